// File: rtl/bht_update_ctrl.sv
// Single-port BHT SRAM access controller: prediction reads, buffered retire-time
// saturating read-modify-write updates, and a write-only init sweep.
module bht_update_ctrl #(
  parameter int BHT_ENTRIES  = 512,
  parameter int IDX_W        = $clog2(BHT_ENTRIES),
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_req_i,
  input  logic             upd0_valid_i,
  input  logic [IDX_W-1:0] upd0_idx_i,
  input  logic             upd0_taken_i,
  output logic             upd0_ready_o,
  input  logic             upd1_valid_i,
  input  logic [IDX_W-1:0] upd1_idx_i,
  input  logic             upd1_taken_i,
  output logic             upd1_ready_o,
  input  logic             pred_req_i,
  input  logic [IDX_W-1:0] pred_idx_i,
  output logic             pred_gnt_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [IDX_W-1:0] mem_addr_o,
  output logic [1:0]       mem_wdata_o,
  input  logic [1:0]       mem_rdata_i,
  output logic             init_done_o
);

  // state | meaning
  // INIT  | sweeping every entry to 2'b01, one write per cycle
  // IDLE  | no update in progress
  // RD    | waiting to issue the read of the FIFO head
  // CAP   | read data returning; capture counter, port free
  // WR    | waiting to issue the saturated counter write
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_RD, S_CAP, S_WR} state_e;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   sweep_q, sweep_d;
  logic [STV_W-1:0]   starve_q, starve_d;
  logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d, free;
  logic [IDX_W-1:0]   fifo_idx_q [FIFO_DEPTH];
  logic               fifo_tkn_q [FIFO_DEPTH];
  logic [IDX_W-1:0]   op_idx_q;
  logic               op_tkn_q;
  logic [1:0]         ctr_q, ctr_new;

  logic active, need_port, preempt, upd_gnt, pop, push0, push1;

  assign active    = !rst_i && (state_q != S_INIT);
  assign free      = CNT_W'(FIFO_DEPTH) - count_q;
  assign upd0_ready_o = active && !flush_req_i && (free >= CNT_W'(1));
  assign upd1_ready_o = active && !flush_req_i && (free >= CNT_W'(2));
  assign push0     = upd0_valid_i && upd0_ready_o;
  assign push1     = upd1_valid_i && upd1_ready_o;

  // Updates yield to prediction until they have been blocked STARVE_LIMIT times.
  assign need_port = active && !flush_req_i && ((state_q == S_RD) || (state_q == S_WR));
  assign preempt   = (starve_q == STV_W'(STARVE_LIMIT));
  assign upd_gnt   = need_port && (!pred_req_i || preempt);
  assign pred_gnt_o = active && pred_req_i && !(need_port && preempt);
  assign pop       = upd_gnt && (state_q == S_RD);
  assign init_done_o = active;

  always_comb begin
    if (op_tkn_q) ctr_new = (ctr_q == 2'b11) ? 2'b11 : ctr_q + 2'b01;
    else          ctr_new = (ctr_q == 2'b00) ? 2'b00 : ctr_q - 2'b01;
  end

  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    starve_d    = starve_q;
    count_d     = count_q + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = 2'b00;

    if (!rst_i && state_q == S_INIT) begin
      mem_req_o   = 1'b1;
      mem_we_o    = 1'b1;
      mem_addr_o  = sweep_q;
      mem_wdata_o = 2'b01;
    end else if (upd_gnt) begin
      mem_req_o   = 1'b1;
      mem_we_o    = (state_q == S_WR);
      mem_addr_o  = (state_q == S_RD) ? fifo_idx_q[rd_ptr_q] : op_idx_q;
      mem_wdata_o = (state_q == S_WR) ? ctr_new : 2'b00;
    end else if (pred_gnt_o) begin
      mem_req_o   = 1'b1;
      mem_addr_o  = pred_idx_i;
    end

    if (need_port) begin
      if (upd_gnt) starve_d = '0;
      else if (!preempt) starve_d = starve_q + STV_W'(1);
    end

    case (state_q)
      S_INIT: begin
        sweep_d = sweep_q + IDX_W'(1);
        if (sweep_q == IDX_W'(BHT_ENTRIES - 1)) state_d = S_IDLE;
      end
      S_IDLE: if (count_q != '0) state_d = S_RD;
      S_RD:   if (pop) state_d = S_CAP;
      S_CAP:  state_d = S_WR;
      S_WR:   if (upd_gnt) state_d = (count_d != '0) ? S_RD : S_IDLE;
      default: state_d = S_INIT;
    endcase

    if (flush_req_i) begin
      state_d = S_INIT;
      sweep_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_INIT;
      sweep_q  <= '0;
      starve_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      sweep_q  <= sweep_d;
      starve_q <= starve_d;
      if (flush_req_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(pop);
        wr_ptr_q <= wr_ptr_q + PTR_W'(push0) + PTR_W'(push1);
        count_q  <= count_d;
      end
    end
  end

  // Datapath storage; validity is tracked entirely by the control registers above.
  always_ff @(posedge clk_i) begin
    if (push0) begin
      fifo_idx_q[wr_ptr_q] <= upd0_idx_i;
      fifo_tkn_q[wr_ptr_q] <= upd0_taken_i;
    end
    if (push1) begin
      fifo_idx_q[wr_ptr_q + PTR_W'(push0)] <= upd1_idx_i;
      fifo_tkn_q[wr_ptr_q + PTR_W'(push0)] <= upd1_taken_i;
    end
    if (pop) begin
      op_idx_q <= fifo_idx_q[rd_ptr_q];
      op_tkn_q <= fifo_tkn_q[rd_ptr_q];
    end
    if (state_q == S_CAP) ctr_q <= mem_rdata_i;
  end

endmodule

// File: tb/tb_bht_update_ctrl.sv
// Directed bench for bht_update_ctrl with a behavioural single-port SRAM model.
module tb_bht_update_ctrl;
  localparam int ENT = 512;
  localparam int IW  = 9;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          flush_req_i = 1'b0;
  logic          upd0_valid_i = 1'b0, upd0_taken_i = 1'b0, upd0_ready_o;
  logic [IW-1:0] upd0_idx_i = '0;
  logic          upd1_valid_i = 1'b0, upd1_taken_i = 1'b0, upd1_ready_o;
  logic [IW-1:0] upd1_idx_i = '0;
  logic          pred_req_i = 1'b0, pred_gnt_o;
  logic [IW-1:0] pred_idx_i = '0;
  logic          mem_req_o, mem_we_o, init_done_o;
  logic [IW-1:0] mem_addr_o;
  logic [1:0]    mem_wdata_o;
  logic [1:0]    mem_rdata_i = 2'b00;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0]    mem [ENT];
  logic [IW+1:0] wlog [$];

  bht_update_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_req_i(flush_req_i),
    .upd0_valid_i(upd0_valid_i), .upd0_idx_i(upd0_idx_i), .upd0_taken_i(upd0_taken_i),
    .upd0_ready_o(upd0_ready_o),
    .upd1_valid_i(upd1_valid_i), .upd1_idx_i(upd1_idx_i), .upd1_taken_i(upd1_taken_i),
    .upd1_ready_o(upd1_ready_o),
    .pred_req_i(pred_req_i), .pred_idx_i(pred_idx_i), .pred_gnt_o(pred_gnt_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .init_done_o(init_done_o)
  );

  always #5 clk_i = ~clk_i;

  // SRAM starts at 2'b11 everywhere so the sweep is visible; post-init writes are logged.
  always @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENT; i++) mem[i] <= 2'b11;
    end else if (mem_req_o) begin
      if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
      else mem_rdata_i <= mem[mem_addr_o];
      if (mem_we_o && init_done_o) wlog.push_back({mem_addr_o, mem_wdata_o});
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ent(input int a, input int d);
    logic [IW+1:0] v;
    v = {IW'(a), 2'(d)};
    return 32'(v);
  endfunction

  function automatic logic [31:0] log_at(input int k);
    if (k < wlog.size()) return 32'(wlog[k]);
    return 32'hFFFF_FFFF;
  endfunction

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_log(input int n, input string tag);
    int i;
    i = 0;
    while (wlog.size() < n && i < 200) begin
      next_cycle();
      i++;
    end
    repeat (2) next_cycle();
    check(tag, wlog.size(), n);
  endtask

  task automatic push0(input int idx, input logic tkn);
    int i;
    upd0_valid_i = 1'b1;
    upd0_idx_i   = IW'(idx);
    upd0_taken_i = tkn;
    i = 0;
    @(negedge clk_i);
    while (!upd0_ready_o && i < 100) begin
      @(negedge clk_i);
      i++;
    end
    check("push0_ready", upd0_ready_o, 1);
    next_cycle();
    upd0_valid_i = 1'b0;
  endtask

  task automatic wait_init(input string tag);
    int i;
    i = 0;
    while (!init_done_o && i < 700) begin
      next_cycle();
      i++;
    end
    check(tag, init_done_o, 1);
  endtask

  initial begin
    int good, bad, expa, lows, first_low, second_low, rd_ok, wr_ok, found;

    // Reset: outputs forced low even with requests pending
    rst_i = 1'b1; pred_req_i = 1'b1; upd0_valid_i = 1'b1; upd1_valid_i = 1'b1;
    repeat (3) next_cycle();
    @(negedge clk_i);
    check("rst_outputs", {pred_gnt_o, upd0_ready_o, upd1_ready_o, mem_req_o, init_done_o}, 0);
    next_cycle();
    rst_i = 1'b0; upd0_valid_i = 1'b0; upd1_valid_i = 1'b0;

    // Init sweep with prediction pressure: no grants, no readiness
    good = 0; bad = 0; expa = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk_i);
      if (init_done_o) break;
      if (mem_req_o && mem_we_o && mem_addr_o == IW'(expa) && mem_wdata_o == 2'b01) good++;
      expa++;
      if (pred_gnt_o || upd0_ready_o || upd1_ready_o) bad++;
      next_cycle();
    end
    check("sweep_writes", good, ENT);
    check("sweep_cycles", expa, ENT);
    check("sweep_no_grant", bad, 0);
    check("init_done", init_done_o, 1);
    check("sweep_pred_gnt_after", pred_gnt_o, 1);
    bad = 0;
    for (int i = 0; i < ENT; i++) if (mem[i] != 2'b01) bad++;
    check("sweep_mem_content", bad, 0);
    next_cycle();
    pred_req_i = 1'b0;

    // Dual-port push to the same index, port 0 first
    wlog.delete();
    upd0_valid_i = 1'b1; upd0_idx_i = 9'd5; upd0_taken_i = 1'b1;
    upd1_valid_i = 1'b1; upd1_idx_i = 9'd5; upd1_taken_i = 1'b0;
    @(negedge clk_i);
    check("dual_ready", {upd0_ready_o, upd1_ready_o}, 2'b11);
    next_cycle();
    upd0_valid_i = 1'b0; upd1_valid_i = 1'b0;
    wait_log(2, "dual_nwr");
    check("dual_w0", log_at(0), ent(5, 2));
    check("dual_w1", log_at(1), ent(5, 1));
    check("dual_mem5", mem[5], 2'b01);

    // Saturation up and down
    wlog.delete();
    for (int k = 0; k < 4; k++) push0(9, 1'b1);
    wait_log(4, "satinc_nwr");
    check("satinc_w0", log_at(0), ent(9, 2));
    check("satinc_w1", log_at(1), ent(9, 3));
    check("satinc_w2", log_at(2), ent(9, 3));
    check("satinc_w3", log_at(3), ent(9, 3));
    wlog.delete();
    for (int k = 0; k < 4; k++) push0(12, 1'b0);
    wait_log(4, "satdec_nwr");
    for (int k = 0; k < 4; k++) check($sformatf("satdec_w%0d", k), log_at(k), ent(12, 0));

    // Starvation: update preempts one prediction read for RD, then one for WR
    wlog.delete();
    pred_req_i = 1'b1; pred_idx_i = 9'd100;
    push0(20, 1'b1);
    lows = 0; first_low = -1; second_low = -1; rd_ok = 0; wr_ok = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_i);
      if (!pred_gnt_o) begin
        lows++;
        if (first_low < 0) begin
          first_low = i;
          rd_ok = int'(mem_req_o && !mem_we_o && mem_addr_o == 9'd20);
        end else if (second_low < 0) begin
          second_low = i;
          wr_ok = int'(mem_req_o && mem_we_o && mem_addr_o == 9'd20 && mem_wdata_o == 2'b10);
        end
      end
      next_cycle();
    end
    check("starve_lows", lows, 2);
    check("starve_rd_cycle", first_low, 9);
    check("starve_wr_cycle", second_low, 19);
    check("starve_rd_access", rd_ok, 1);
    check("starve_wr_access", wr_ok, 1);
    check("starve_log", log_at(0), ent(20, 2));
    pred_req_i = 1'b0;
    next_cycle();

    // Fill the FIFO while prediction blocks the RMW
    wlog.delete();
    pred_req_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      upd0_valid_i = 1'b1; upd0_idx_i = IW'(30 + k); upd0_taken_i = 1'b1;
      @(negedge clk_i);
      check($sformatf("fill_rdy0_%0d", k), upd0_ready_o, 1);
      check($sformatf("fill_rdy1_%0d", k), upd1_ready_o, (k < 3) ? 1 : 0);
      next_cycle();
    end
    upd0_valid_i = 1'b0;
    @(negedge clk_i);
    check("full_ready", {upd0_ready_o, upd1_ready_o}, 2'b00);
    next_cycle();
    pred_req_i = 1'b0;
    wait_log(4, "fill_nwr");
    for (int k = 0; k < 4; k++) check($sformatf("fill_w%0d", k), log_at(k), ent(30 + k, 2));

    // Flush while in CAP with two updates still queued
    wlog.delete();
    upd0_valid_i = 1'b1; upd0_idx_i = 9'd40; upd0_taken_i = 1'b1;
    upd1_valid_i = 1'b1; upd1_idx_i = 9'd41; upd1_taken_i = 1'b1;
    next_cycle();
    upd1_valid_i = 1'b0; upd0_idx_i = 9'd42;
    next_cycle();
    upd0_valid_i = 1'b0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (mem_req_o && !mem_we_o) begin
        found = 1;
        break;
      end
      next_cycle();
    end
    check("flush_rd_seen", found, 1);
    next_cycle();
    flush_req_i = 1'b1;
    @(negedge clk_i);
    check("flush_cap_no_access", mem_req_o, 0);
    next_cycle();
    flush_req_i = 1'b0;
    @(negedge clk_i);
    check("flush_init_done", init_done_o, 0);
    check("flush_sweep_start", {mem_req_o, mem_we_o, 2'b00, mem_addr_o, mem_wdata_o}, {2'b11, 2'b00, 9'd0, 2'b01});
    check("flush_ready", {upd0_ready_o, upd1_ready_o}, 2'b00);
    wait_init("flush_reinit");
    repeat (8) next_cycle();
    check("flush_no_wr", wlog.size(), 0);
    check("flush_mem40", mem[40], 2'b01);
    check("flush_mem41", mem[41], 2'b01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
